// File: rtl/wisard_pkg.sv
// Shared WiSARD definitions: FSM state encoding, default geometry constants
// and the minimum inter-sample gap helper.
package wisard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDRESS_WIDTH = 8;
  localparam int unsigned DEF_INDEX_WIDTH   = 7;
  localparam int unsigned DEF_N_LUTS        = 98;

  // The classifier's argmax scans one class per cycle and overlaps the next
  // sample's stream, so a gap is only needed when classes outnumber tuples.
  function automatic int unsigned min_gap_cycles(input int unsigned n_classes,
                                                 input int unsigned n_luts);
    return (n_classes > n_luts) ? (n_classes - n_luts) : 32'd0;
  endfunction

endpackage

// File: rtl/wisard_tuple_mux.sv
// Combinational selection of address tuple 'sel' from a packed sample.
module wisard_tuple_mux #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned INDEX_WIDTH   = 7,
  parameter int unsigned N_LUTS        = 98
) (
  input  logic [N_LUTS*ADDRESS_WIDTH-1:0] sample,
  input  logic [INDEX_WIDTH-1:0]          sel,
  output logic [ADDRESS_WIDTH-1:0]        tuple
);

  always_comb begin
    tuple = '0;
    for (int unsigned k = 0; k < N_LUTS; k++) begin
      if (sel == INDEX_WIDTH'(k)) tuple = sample[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end
  end

endmodule

// File: rtl/wisard_addr_gen.sv
// Slices one input sample into N_LUTS (addr, index) beats for the WiSARD
// classifier sink. Optional prefetch register: define WISARD_AG_PREFETCH_EN.
module wisard_addr_gen
  import wisard_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned INDEX_WIDTH   = DEF_INDEX_WIDTH,
  parameter int unsigned N_LUTS        = DEF_N_LUTS,
  parameter int unsigned GAP_CYCLES    = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_LUTS*ADDRESS_WIDTH-1:0] in_data,
  output logic                            source_valid,
  output logic                            sop,
  output logic                            eop,
  output logic [ADDRESS_WIDTH-1:0]        addr,
  output logic [INDEX_WIDTH-1:0]          index
);

  localparam int unsigned SW = N_LUTS * ADDRESS_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_BEAT = INDEX_WIDTH'(N_LUTS - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t                   state, state_nx;
  logic [INDEX_WIDTH-1:0]   beat, beat_nx;
  logic [7:0]               gap_cnt, gap_cnt_nx;
  logic [SW-1:0]            sample_reg, sample_nx;
  logic [ADDRESS_WIDTH-1:0] tuple_nx;
  logic                     hs, launch;

`ifdef WISARD_AG_PREFETCH_EN
  logic [SW-1:0] pf_reg, pf_nx;
  logic          pf_full, pf_full_nx, pf_take, pf_fill, final_cycle;
  assign in_ready = ~pf_full;
`else
  assign in_ready = (state == IDLE);
`endif

  assign hs = in_valid & in_ready;

  always_comb begin
    state_nx   = state;
    beat_nx    = beat;
    gap_cnt_nx = gap_cnt;
    sample_nx  = sample_reg;
    launch     = 1'b0;
`ifdef WISARD_AG_PREFETCH_EN
    pf_nx       = pf_reg;
    pf_take     = 1'b0;
    pf_fill     = hs && (state != IDLE);
    final_cycle = (state == STREAM && beat == LAST_BEAT && GAP_CYCLES == 0) ||
                  (state == GAP && gap_cnt == '0);
`endif
    case (state)
      IDLE: begin
`ifdef WISARD_AG_PREFETCH_EN
        if (pf_full) begin
          launch    = 1'b1;
          sample_nx = pf_reg;
          pf_take   = 1'b1;
        end else
`endif
        if (hs) begin
          launch    = 1'b1;
          sample_nx = in_data;
        end
      end
      STREAM: begin
        if (beat == LAST_BEAT) begin
          if (GAP_CYCLES > 0) begin
            state_nx   = GAP;
            gap_cnt_nx = GAP_LAST;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          beat_nx = beat + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nx = IDLE;
        else               gap_cnt_nx = gap_cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
`ifdef WISARD_AG_PREFETCH_EN
    // A held sample launches straight out of the last busy cycle, skipping IDLE.
    if (final_cycle && pf_full) begin
      launch    = 1'b1;
      sample_nx = pf_reg;
      pf_take   = 1'b1;
    end
    if (pf_fill) pf_nx = in_data;
    pf_full_nx = (pf_full & ~pf_take) | pf_fill;
`endif
    if (launch) begin
      state_nx = STREAM;
      beat_nx  = '0;
    end
  end

  wisard_tuple_mux #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .INDEX_WIDTH  (INDEX_WIDTH),
    .N_LUTS       (N_LUTS)
  ) u_tuple_mux (
    .sample(sample_nx),
    .sel   (beat_nx),
    .tuple (tuple_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat         <= '0;
      gap_cnt      <= '0;
      sample_reg   <= '0;
      source_valid <= 1'b0;
      sop          <= 1'b0;
      eop          <= 1'b0;
      addr         <= '0;
      index        <= '0;
    end else begin
      state      <= state_nx;
      beat       <= beat_nx;
      gap_cnt    <= gap_cnt_nx;
      sample_reg <= sample_nx;
      // Output registers are loaded with the beat that the next cycle carries.
      if (state_nx == STREAM) begin
        source_valid <= 1'b1;
        sop          <= (beat_nx == '0);
        eop          <= (beat_nx == LAST_BEAT);
        addr         <= tuple_nx;
        index        <= beat_nx;
      end else begin
        source_valid <= 1'b0;
        sop          <= 1'b0;
        eop          <= 1'b0;
      end
    end
  end

`ifdef WISARD_AG_PREFETCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_reg  <= '0;
      pf_full <= 1'b0;
    end else begin
      pf_reg  <= pf_nx;
      pf_full <= pf_full_nx;
    end
  end
`endif

endmodule

// File: tb/tb_wisard_addr_gen.sv
// Directed bench for wisard_addr_gen: three parameterisations sharing clk/rst_n.
module tb_wisard_addr_gen;

`ifdef WISARD_AG_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // dut_a: N_LUTS=4, GAP_CYCLES=3
  logic        iv_a = 1'b0, ir_a, sv_a, sop_a, eop_a;
  logic [31:0] id_a = '0;
  logic [7:0]  addr_a;
  logic [6:0]  idx_a;
  // dut_b: N_LUTS=1, GAP_CYCLES=0
  logic        iv_b = 1'b0, ir_b, sv_b, sop_b, eop_b;
  logic [7:0]  id_b = '0;
  logic [7:0]  addr_b;
  logic [6:0]  idx_b;
  // dut_c: N_LUTS=4, GAP_CYCLES=0
  logic        iv_c = 1'b0, ir_c, sv_c, sop_c, eop_c;
  logic [31:0] id_c = '0;
  logic [7:0]  addr_c;
  logic [6:0]  idx_c;

  wisard_addr_gen #(.ADDRESS_WIDTH(8), .INDEX_WIDTH(7), .N_LUTS(4), .GAP_CYCLES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .source_valid(sv_a), .sop(sop_a), .eop(eop_a), .addr(addr_a), .index(idx_a));

  wisard_addr_gen #(.ADDRESS_WIDTH(8), .INDEX_WIDTH(7), .N_LUTS(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .source_valid(sv_b), .sop(sop_b), .eop(eop_b), .addr(addr_b), .index(idx_b));

  wisard_addr_gen #(.ADDRESS_WIDTH(8), .INDEX_WIDTH(7), .N_LUTS(4), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
    .source_valid(sv_c), .sop(sop_c), .eop(eop_c), .addr(addr_c), .index(idx_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({sv_a, sop_a, eop_a, addr_a, idx_a, ir_a} !== {3'b000, 8'h00, 7'd0, 1'b1})
      $display("FAIL reset_a got %b want %b", {sv_a, sop_a, eop_a, addr_a, idx_a, ir_a},
               {3'b000, 8'h00, 7'd0, 1'b1});
    else passes++;
    checks++;
    if ({sv_b, sop_b, eop_b, addr_b, idx_b, sv_c, sop_c, eop_c, addr_c, idx_c} !== '0)
      $display("FAIL reset_bc got %b want 0",
               {sv_b, sop_b, eop_b, addr_b, idx_b, sv_c, sop_c, eop_c, addr_c, idx_c});
    else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_sample;
    logic [31:0] d;
    logic [7:0]  ea;
    d = 32'hDDCCBBAA;
    checks++;
    if (ir_a !== 1'b1) $display("FAIL single_idle_ready got %b want 1", ir_a);
    else passes++;
    id_a = d; iv_a = 1'b1;
    tick();
    iv_a = 1'b0; id_a = '0;
    for (int b = 0; b < 4; b++) begin
      ea = d[b*8 +: 8];
      checks++;
      if ({sv_a, sop_a, eop_a, addr_a, idx_a, ir_a} !== {1'b1, b == 0, b == 3, ea, 7'(b), PF})
        $display("FAIL single_beat%0d got %b want %b", b, {sv_a, sop_a, eop_a, addr_a, idx_a, ir_a},
                 {1'b1, b == 0, b == 3, ea, 7'(b), PF});
      else passes++;
      tick();
    end
    checks++;
    if ({sv_a, sop_a, eop_a, addr_a, idx_a, ir_a} !== {3'b000, 8'hDD, 7'd3, PF})
      $display("FAIL single_gap_hold got %b want %b", {sv_a, sop_a, eop_a, addr_a, idx_a, ir_a},
               {3'b000, 8'hDD, 7'd3, PF});
    else passes++;
    tick(); tick();
    checks++;
    if ({sv_a, ir_a} !== {1'b0, PF}) $display("FAIL single_gap_end got %b want %b", {sv_a, ir_a}, {1'b0, PF});
    else passes++;
    tick();
    checks++;
    if ({sv_a, ir_a} !== 2'b01) $display("FAIL single_idle_again got %b want 01", {sv_a, ir_a});
    else passes++;
  endtask

  task automatic test_gap_period;
    int first, second;
    first = -1; second = -1;
    id_a = 32'h44332211; iv_a = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (sop_a === 1'b1) begin
        if (first < 0) begin
          first = cyc;
          checks++;
          if (addr_a !== 8'h11) $display("FAIL period_first_addr got %h want 11", addr_a);
          else passes++;
          id_a = 32'h88776655;
        end else if (second < 0) begin
          second = cyc;
          checks++;
          if (addr_a !== 8'h55) $display("FAIL period_second_addr got %h want 55", addr_a);
          else passes++;
        end
      end
    end
    iv_a = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) !== (PF ? 7 : 8))
      $display("FAIL gap_period got %0d want %0d", second - first, PF ? 7 : 8);
    else passes++;
    repeat (20) tick();
  endtask

  task automatic test_single_lut;
    id_b = 8'h5A; iv_b = 1'b1;
    tick();
    iv_b = 1'b0; id_b = 8'h00;
    checks++;
    if ({sv_b, sop_b, eop_b, addr_b, idx_b} !== {3'b111, 8'h5A, 7'd0})
      $display("FAIL n1_beat got %b want %b", {sv_b, sop_b, eop_b, addr_b, idx_b}, {3'b111, 8'h5A, 7'd0});
    else passes++;
    tick();
    checks++;
    if ({sv_b, sop_b, eop_b, addr_b, ir_b} !== {3'b000, 8'h5A, 1'b1})
      $display("FAIL n1_after got %b want %b", {sv_b, sop_b, eop_b, addr_b, ir_b}, {3'b000, 8'h5A, 1'b1});
    else passes++;
  endtask

  task automatic test_reset_mid_stream;
    logic [31:0] d;
    id_a = 32'hDDCCBBAA; iv_a = 1'b1;
    tick();
    iv_a = 1'b0;
    tick(); tick();
    checks++;
    if ({sv_a, idx_a, addr_a} !== {1'b1, 7'd2, 8'hCC})
      $display("FAIL rst_mid_beat2 got %b want %b", {sv_a, idx_a, addr_a}, {1'b1, 7'd2, 8'hCC});
    else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sv_a, sop_a, eop_a, addr_a, idx_a, ir_a} !== {3'b000, 8'h00, 7'd0, 1'b1})
      $display("FAIL rst_mid_async got %b want %b", {sv_a, sop_a, eop_a, addr_a, idx_a, ir_a},
               {3'b000, 8'h00, 7'd0, 1'b1});
    else passes++;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sv_a, eop_a} !== 2'b00) $display("FAIL rst_mid_no_eop%0d got %b want 00", i, {sv_a, eop_a});
      else passes++;
    end
    d = 32'h0D0C0B0A;
    id_a = d; iv_a = 1'b1;
    tick();
    iv_a = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({sv_a, sop_a, eop_a, addr_a, idx_a} !== {1'b1, b == 0, b == 3, d[b*8 +: 8], 7'(b)})
        $display("FAIL rst_recover_beat%0d got %b want %b", b, {sv_a, sop_a, eop_a, addr_a, idx_a},
                 {1'b1, b == 0, b == 3, d[b*8 +: 8], 7'(b)});
      else passes++;
      tick();
    end
    repeat (6) tick();
  endtask

  task automatic test_back_to_back;
    id_c = 32'hA3A2A1A0; iv_c = 1'b1;
    tick();
    iv_c = 1'b0;
    checks++;
    if ({sv_c, sop_c, addr_c} !== {2'b11, 8'hA0}) $display("FAIL b2b_beat0 got %b want %b", {sv_c, sop_c, addr_c}, {2'b11, 8'hA0});
    else passes++;
    tick();
    iv_c = 1'b1; id_c = 32'hB3B2B1B0;
    checks++;
    if ({idx_c, ir_c} !== {7'd1, PF}) $display("FAIL b2b_beat1_ready got %b want %b", {idx_c, ir_c}, {7'd1, PF});
    else passes++;
    tick();
    id_c = 32'hC3C2C1C0;
    checks++;
    if ({idx_c, ir_c} !== {7'd2, 1'b0}) $display("FAIL b2b_beat2_refuse got %b want %b", {idx_c, ir_c}, {7'd2, 1'b0});
    else passes++;
    tick();
    checks++;
    if ({eop_c, addr_c, ir_c} !== {1'b1, 8'hA3, 1'b0}) $display("FAIL b2b_eop got %b want %b", {eop_c, addr_c, ir_c}, {1'b1, 8'hA3, 1'b0});
    else passes++;
    tick();
    if (PF) begin
      checks++;
      if ({sv_c, sop_c, addr_c, idx_c} !== {2'b11, 8'hB0, 7'd0})
        $display("FAIL b2b_prefetch_next got %b want %b", {sv_c, sop_c, addr_c, idx_c}, {2'b11, 8'hB0, 7'd0});
      else passes++;
    end else begin
      checks++;
      if ({sv_c, ir_c} !== 2'b01) $display("FAIL b2b_idle got %b want 01", {sv_c, ir_c});
      else passes++;
      tick();
      checks++;
      if ({sv_c, sop_c, addr_c, idx_c} !== {2'b11, 8'hC0, 7'd0})
        $display("FAIL b2b_next got %b want %b", {sv_c, sop_c, addr_c, idx_c}, {2'b11, 8'hC0, 7'd0});
      else passes++;
    end
    iv_c = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_sample();
    test_gap_period();
    test_single_lut();
    test_reset_mid_stream();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
